intr_ctrl: RTL

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/intr_ctrl.sv
// Priority interrupt controller with nesting: latches requests into a pending
// register, arbitrates against the in-service stack, and tracks ack/iret misuse.
module intr_ctrl #(
  parameter  int N_IRQ = 8,
  parameter  int EDGE  = 1,
  parameter  int NEST  = 4,
  localparam int ID_W  = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             ack,
  input  logic             iret,
  output logic             intr_req,
  output logic [ID_W-1:0]  intr_id,
  output logic [N_IRQ-1:0] intr_onehot,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic             err
);

  localparam int CNT_W = $clog2(N_IRQ + 1);

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic [N_IRQ-1:0] intr_onehot_q, intr_onehot_d;
  logic [ID_W-1:0]  intr_id_q, intr_id_d;
  logic             intr_req_q, intr_req_d;
  logic             err_q, err_d;

  logic             ack_ok;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] eligible;
  logic [ID_W-1:0]  h_idx, s_idx;
  logic [CNT_W-1:0] isr_cnt;
  logic             cand;

  // The registered one-hot is nonzero only while a request is shown, so it
  // directly names the line being accepted.
  assign ack_ok   = ack & intr_req_q;
  assign ack_clr  = ack_ok ? intr_onehot_q : '0;
  assign eligible = pending_q & mask_q;

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
    if (EDGE != 0) begin : g_edge
      // A new rising edge wins over a simultaneous ack of the same line.
      assign pending_d[gi] = (irq[gi] & ~irq_q[gi]) | (pending_q[gi] & ~ack_clr[gi]);
    end else begin : g_level
      assign pending_d[gi] = irq[gi];
    end
  end

  always_comb begin
    h_idx   = '0;
    s_idx   = '0;
    isr_cnt = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i])     h_idx = ID_W'(i);
      if (in_service_q[i]) s_idx = ID_W'(i);
    end
    for (int i = 0; i < N_IRQ; i++) begin
      isr_cnt = isr_cnt + CNT_W'(in_service_q[i]);
    end
    cand = (eligible != '0) && (isr_cnt < CNT_W'(NEST)) &&
           ((in_service_q == '0) || (h_idx < s_idx));
  end

  always_comb begin
    intr_req_d    = cand & ~ack_ok;
    intr_id_d     = intr_req_d ? h_idx : '0;
    intr_onehot_d = intr_req_d ? (N_IRQ'(1) << h_idx) : '0;
    mask_d        = mask_we ? mask_in : mask_q;
    // iret pops the highest-priority active level before ack pushes the new one.
    in_service_d  = (iret ? (in_service_q & (in_service_q - N_IRQ'(1))) : in_service_q) | ack_clr;
    err_d         = err_q | (ack & ~intr_req_q) | (iret & ~(|in_service_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q         <= '0;
      pending_q     <= '0;
      mask_q        <= '0;
      in_service_q  <= '0;
      intr_req_q    <= 1'b0;
      intr_id_q     <= '0;
      intr_onehot_q <= '0;
      err_q         <= 1'b0;
    end else begin
      irq_q         <= irq;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      in_service_q  <= in_service_d;
      intr_req_q    <= intr_req_d;
      intr_id_q     <= intr_id_d;
      intr_onehot_q <= intr_onehot_d;
      err_q         <= err_d;
    end
  end

  assign intr_req    = intr_req_q;
  assign intr_id     = intr_id_q;
  assign intr_onehot = intr_onehot_q;
  assign pending     = pending_q;
  assign in_service  = in_service_q;
  assign err         = err_q;

endmodule
